// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the signalised-intersection blocks.
//   - 3-bit state encodings of the two-approach phase scheduler
//   - lamp bundle struct {red, yellow, green} and its NS/EW pair
//   - lamp_decode(): Moore decode from a state code to both lamp bundles.
//     The single-approach light also calls this, so the encodings here
//     are the contract between those blocks.
package traffic_pkg;

   localparam int unsigned ST_W = 3;

   localparam logic [ST_W-1:0] ST_OFF      = 3'd0;
   localparam logic [ST_W-1:0] ST_ALLRED_A = 3'd1;
   localparam logic [ST_W-1:0] ST_NS_GO    = 3'd2;
   localparam logic [ST_W-1:0] ST_NS_WARN  = 3'd3;
   localparam logic [ST_W-1:0] ST_ALLRED_B = 3'd4;
   localparam logic [ST_W-1:0] ST_EW_GO    = 3'd5;
   localparam logic [ST_W-1:0] ST_EW_WARN  = 3'd6;
   localparam logic [ST_W-1:0] ST_FLASH    = 3'd7;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

   typedef struct packed {
      lamp_t ns;
      lamp_t ew;
   } lamp_pair_t;

   // blink only matters in FLASH, where both yellows follow it and every
   // other lamp is dark. OFF (and any unlisted code) leaves every lamp dark.
   function automatic lamp_pair_t lamp_decode(input logic [ST_W-1:0] state,
                                              input logic            blink);
      lamp_pair_t l;
      l = '0;
      case (state)
         ST_ALLRED_A, ST_ALLRED_B: begin
            l.ns.red = 1'b1;
            l.ew.red = 1'b1;
         end
         ST_NS_GO: begin
            l.ns.green = 1'b1;
            l.ew.red   = 1'b1;
         end
         ST_NS_WARN: begin
            l.ns.yellow = 1'b1;
            l.ew.red    = 1'b1;
         end
         ST_EW_GO: begin
            l.ew.green = 1'b1;
            l.ns.red   = 1'b1;
         end
         ST_EW_WARN: begin
            l.ew.yellow = 1'b1;
            l.ns.red    = 1'b1;
         end
         ST_FLASH: begin
            l.ns.yellow = blink;
            l.ew.yellow = blink;
         end
         default: l = '0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
// Saturating tick counter that measures how long the scheduler has sat in
// its current phase, and flags when the requested duration is used up.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the count (asserted on every phase change)
//   enable    - count only while the current phase is a timed one
//   tick      - one-second enable pulse
//   dur       - duration of the current phase, in ticks (>= 1)
//   expire    - this tick completes the duration
module dwell_timer #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             tick,
   input  logic [CNT_W-1:0] dur,
   output logic             expire
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt;

   // Count ticks; hold at all-ones so a green waiting on a cross request
   // never wraps back below its minimum.
   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (enable && tick && (cnt != CNT_MAX))
         cnt <= cnt + 1'b1;
   end

   // The tick that would push the count to dur is the last one of the phase,
   // so the phase leaves on that edge rather than one tick later.
   assign expire = enable && tick && (cnt >= (dur - 1'b1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Two-approach (north-south / east-west) signal scheduler. Steps both lamp
// sets through all-red, green, yellow phases on a one-second tick, holds a
// green until the cross approach has a vehicle waiting, and offers a
// flashing-yellow fault mode.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   tick               - one-clk enable, once per second (external prescaler)
//   ns_req, ew_req     - vehicle detectors, level
//   flash              - fault/maintenance request, level
//   ns_red/yellow/green, ew_red/yellow/green - lamp drives
//   phase              - current state code for status/debug
module intersection_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_S  = 30,
   parameter int unsigned YELLOW_S = 3,
   parameter int unsigned ALLRED_S = 1,
   parameter int unsigned CNT_W    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ns_req,
   input  logic       ew_req,
   input  logic       flash,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic [2:0] phase
);

   localparam int unsigned DUR_MAX = (1 << CNT_W) - 1;

   // A duration the counter cannot reach would lock the scheduler in place.
   if (GREEN_S < 1 || GREEN_S > DUR_MAX)
      $fatal(1, "GREEN_S out of range for CNT_W");
   if (YELLOW_S < 1 || YELLOW_S > DUR_MAX)
      $fatal(1, "YELLOW_S out of range for CNT_W");
   if (ALLRED_S < 1 || ALLRED_S > DUR_MAX)
      $fatal(1, "ALLRED_S out of range for CNT_W");

   localparam logic [CNT_W-1:0] GREEN_D  = CNT_W'(GREEN_S);
   localparam logic [CNT_W-1:0] YELLOW_D = CNT_W'(YELLOW_S);
   localparam logic [CNT_W-1:0] ALLRED_D = CNT_W'(ALLRED_S);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_nxt;
   logic             ns_pend;
   logic             ew_pend;
   logic             blink;
   logic             timed;
   logic             expire;
   logic             change;
   logic [CNT_W-1:0] dur;
   lamp_pair_t       lamps;

   assign timed  = (state != ST_OFF) && (state != ST_FLASH);
   assign change = (state_nxt != state);

   // One shared timer; the duration it compares against follows the phase.
   always_comb begin
      dur = ALLRED_D;
      case (state)
         ST_NS_GO,   ST_EW_GO:   dur = GREEN_D;
         ST_NS_WARN, ST_EW_WARN: dur = YELLOW_D;
         default:                dur = ALLRED_D;
      endcase
   end

   dwell_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (change),
      .enable (timed),
      .tick   (tick),
      .dur    (dur),
      .expire (expire)
   );

   // Next-state logic. flash overrides everything; a green only yields once
   // its minimum has elapsed and the cross approach is asking (either a
   // latched request or one arriving on this very cycle).
   always_comb begin
      state_nxt = state;
      if (flash) begin
         state_nxt = ST_FLASH;
      end else begin
         case (state)
            ST_OFF:      state_nxt = ST_ALLRED_A;
            ST_ALLRED_A: if (expire) state_nxt = ST_NS_GO;
            ST_NS_GO:    if (expire && (ew_pend || ew_req)) state_nxt = ST_NS_WARN;
            ST_NS_WARN:  if (expire) state_nxt = ST_ALLRED_B;
            ST_ALLRED_B: if (expire) state_nxt = ST_EW_GO;
            ST_EW_GO:    if (expire && (ns_pend || ns_req)) state_nxt = ST_EW_WARN;
            ST_EW_WARN:  if (expire) state_nxt = ST_ALLRED_A;
            ST_FLASH:    state_nxt = ST_ALLRED_A;
            default:     state_nxt = ST_OFF;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_OFF;
      else
         state <= state_nxt;
   end

   // Request latches remember a vehicle that showed up while its approach
   // was red. Entering that approach's green serves it, and that clear wins
   // over a request seen on the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ns_pend <= 1'b0;
         ew_pend <= 1'b0;
      end else begin
         if (state_nxt == ST_NS_GO && state != ST_NS_GO)
            ns_pend <= 1'b0;
         else if (ns_req && state != ST_NS_GO)
            ns_pend <= 1'b1;

         if (state_nxt == ST_EW_GO && state != ST_EW_GO)
            ew_pend <= 1'b0;
         else if (ew_req && state != ST_EW_GO)
            ew_pend <= 1'b1;
      end
   end

   // Flash always starts dark and then toggles once per second.
   always_ff @(posedge clk) begin
      if (rst)
         blink <= 1'b0;
      else if (state_nxt == ST_FLASH && state != ST_FLASH)
         blink <= 1'b0;
      else if (state == ST_FLASH && tick)
         blink <= ~blink;
   end

   assign lamps     = lamp_decode(state, blink);
   assign ns_red    = lamps.ns.red;
   assign ns_yellow = lamps.ns.yellow;
   assign ns_green  = lamps.ns.green;
   assign ew_red    = lamps.ew.red;
   assign ew_yellow = lamps.ew.yellow;
   assign ew_green  = lamps.ew.green;
   assign phase     = state;

endmodule
